// File: rtl/load_unit_pkg.sv
// rtl/load_unit_pkg.sv - shared load funct3 codes, FSM state encoding and misalignment helper
// Purpose: common definitions imported by load_unit and load_align_ext.
// Contents: F3_* funct3 codes, lu_state_t FSM encoding, is_misaligned() classifier.
package load_unit_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;

  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_REQ  = 2'b01,
    ST_WAIT = 2'b10,
    ST_RESP = 2'b11
  } lu_state_t;

  // Halves need an even offset, words need offset 0; byte loads and the
  // unused codes can never be misaligned.
  function automatic logic is_misaligned(input logic [2:0] f3, input logic [1:0] off);
    case (f3)
      F3_LH, F3_LHU: return off[0];
      F3_LW:         return (off != 2'b00);
      default:       return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/load_align_ext.sv
// rtl/load_align_ext.sv - combinational byte/half/word extraction with sign/zero extension
// Purpose: select the addressed lane of a raw memory word and extend it to 32 bits.
// Ports:
//   funct3_in  in  3   load type (LB/LH/LW/LBU/LHU, other codes pass the word through)
//   off_in     in  2   byte offset within the word
//   word_in    in  32  raw aligned memory word
//   result_out out 32  extended load result
module load_align_ext
  import load_unit_pkg::*;
(
  input  logic [2:0]  funct3_in,
  input  logic [1:0]  off_in,
  input  logic [31:0] word_in,
  output logic [31:0] result_out
);

  logic [31:0] shifted;
  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  // Shifting by 8*off puts the addressed byte in the low lane.
  assign shifted  = word_in >> {off_in, 3'b000};
  assign byte_sel = shifted[7:0];
  // Halves only look at off[1]; off[0] is either trapped upstream or ignored.
  assign half_sel = off_in[1] ? word_in[31:16] : word_in[15:0];

  always_comb begin
    result_out = word_in;
    case (funct3_in)
      F3_LB:   result_out = {{24{byte_sel[7]}}, byte_sel};
      F3_LBU:  result_out = {24'h000000, byte_sel};
      F3_LH:   result_out = {{16{half_sel[15]}}, half_sel};
      F3_LHU:  result_out = {16'h0000, half_sel};
      default: result_out = word_in;
    endcase
  end

endmodule

// File: rtl/load_unit.sv
// rtl/load_unit.sv - single-outstanding load unit between execute, data memory and writeback
// Purpose: accept one load, issue an aligned word read, wait for memory, extract/extend the
//   addressed lane and hold the result on a valid/ready handshake to writeback.
// Optional feature: MISALIGN_TRAP_EN - misaligned LH/LHU/LW skip memory and complete with
//   misaligned_out=1 and zero data; without it the port is absent and offsets are ignored.
// Ports:
//   clk_in, rst_n_in            clock, asynchronous active-low reset
//   ld_req_in / ld_ready_out    load request from execute / ready (IDLE only)
//   funct3_in, iadder_in        load type and effective byte address
//   dmrd_req_out, dmaddr_out    memory read request and aligned word address
//   dmgnt_in                    memory accepted the request
//   dmdata_in, dmdata_valid_in  returned word and its valid strobe
//   lu_output_out, lu_valid_out result to writeback, held until lu_ready_in
//   lu_ready_in                 writeback consumes the result
//   misaligned_out              (MISALIGN_TRAP_EN only) qualifies lu_valid_out
module load_unit
  import load_unit_pkg::*;
#(
  parameter int ADDR_WIDTH = 32
) (
  input  logic                  clk_in,
  input  logic                  rst_n_in,
  input  logic                  ld_req_in,
  output logic                  ld_ready_out,
  input  logic [2:0]            funct3_in,
  input  logic [ADDR_WIDTH-1:0] iadder_in,
  output logic                  dmrd_req_out,
  output logic [ADDR_WIDTH-1:0] dmaddr_out,
  input  logic                  dmgnt_in,
  input  logic [31:0]           dmdata_in,
  input  logic                  dmdata_valid_in,
  output logic [31:0]           lu_output_out,
  output logic                  lu_valid_out,
`ifdef MISALIGN_TRAP_EN
  output logic                  misaligned_out,
`endif
  input  logic                  lu_ready_in
);

  lu_state_t   state, next_state;
  logic [2:0]  cap_funct3;
  logic [1:0]  cap_off;
  logic [31:0] ext_data;

`ifdef MISALIGN_TRAP_EN
  logic trap;
  assign trap = is_misaligned(funct3_in, iadder_in[1:0]);
`endif

  load_align_ext u_align_ext (
    .funct3_in  (cap_funct3),
    .off_in     (cap_off),
    .word_in    (dmdata_in),
    .result_out (ext_data)
  );

  // State register
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state <= ST_IDLE;
    end else begin
      state <= next_state;
    end
  end

  // Next-state logic
  always_comb begin
    next_state = state;
    case (state)
      ST_IDLE: begin
        if (ld_req_in) begin
`ifdef MISALIGN_TRAP_EN
          next_state = trap ? ST_RESP : ST_REQ;
`else
          next_state = ST_REQ;
`endif
        end
      end
      ST_REQ:  if (dmgnt_in)        next_state = ST_WAIT;
      ST_WAIT: if (dmdata_valid_in) next_state = ST_RESP;
      ST_RESP: if (lu_ready_in)     next_state = ST_IDLE;
      default: next_state = ST_IDLE;
    endcase
  end

  // Control outputs are pure state decodes, so they clear with the state on reset.
  always_comb begin
    ld_ready_out = (state == ST_IDLE);
    dmrd_req_out = (state == ST_REQ);
    lu_valid_out = (state == ST_RESP);
  end

  // Captured request fields and the registered result. Data arriving outside
  // WAIT (e.g. a response to a load dropped by reset) never reaches the output.
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      cap_funct3    <= 3'b000;
      cap_off       <= 2'b00;
      dmaddr_out    <= '0;
      lu_output_out <= 32'h0000_0000;
`ifdef MISALIGN_TRAP_EN
      misaligned_out <= 1'b0;
`endif
    end else begin
      case (state)
        ST_IDLE: begin
          if (ld_req_in) begin
            cap_funct3 <= funct3_in;
            cap_off    <= iadder_in[1:0];
            dmaddr_out <= {iadder_in[ADDR_WIDTH-1:2], 2'b00};
`ifdef MISALIGN_TRAP_EN
            if (trap) begin
              lu_output_out  <= 32'h0000_0000;
              misaligned_out <= 1'b1;
            end
`endif
          end
        end
        ST_WAIT: begin
          if (dmdata_valid_in) begin
            lu_output_out <= ext_data;
          end
        end
        ST_RESP: begin
`ifdef MISALIGN_TRAP_EN
          if (lu_ready_in) begin
            misaligned_out <= 1'b0;
          end
`endif
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_load_unit.sv
// tb/tb_load_unit.sv - directed self-checking bench for load_unit
module tb_load_unit;
  import load_unit_pkg::*;

  logic        clk_in = 1'b0;
  logic        rst_n_in = 1'b0;
  logic        ld_req_in = 1'b0;
  logic        ld_ready_out;
  logic [2:0]  funct3_in = 3'b000;
  logic [31:0] iadder_in = 32'h0;
  logic        dmrd_req_out;
  logic [31:0] dmaddr_out;
  logic        dmgnt_in = 1'b0;
  logic [31:0] dmdata_in = 32'h5A5A_5A5A;
  logic        dmdata_valid_in = 1'b0;
  logic [31:0] lu_output_out;
  logic        lu_valid_out;
  logic        lu_ready_in = 1'b0;
`ifdef MISALIGN_TRAP_EN
  logic        misaligned_out;
`endif

  int n_cmp = 0;
  int n_err = 0;

  load_unit #(.ADDR_WIDTH(32)) dut (
    .clk_in          (clk_in),
    .rst_n_in        (rst_n_in),
    .ld_req_in       (ld_req_in),
    .ld_ready_out    (ld_ready_out),
    .funct3_in       (funct3_in),
    .iadder_in       (iadder_in),
    .dmrd_req_out    (dmrd_req_out),
    .dmaddr_out      (dmaddr_out),
    .dmgnt_in        (dmgnt_in),
    .dmdata_in       (dmdata_in),
    .dmdata_valid_in (dmdata_valid_in),
    .lu_output_out   (lu_output_out),
    .lu_valid_out    (lu_valid_out),
`ifdef MISALIGN_TRAP_EN
    .misaligned_out  (misaligned_out),
`endif
    .lu_ready_in     (lu_ready_in)
  );

  always #5 clk_in = ~clk_in;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic tick;
    @(posedge clk_in);
    #1;
  endtask

  task automatic issue(input logic [2:0] f3, input logic [31:0] addr);
    ld_req_in = 1'b1;
    funct3_in = f3;
    iadder_in = addr;
    tick();
    ld_req_in = 1'b0;
    iadder_in = 32'hFFFF_FFFF;
    funct3_in = 3'b111;
  endtask

  task automatic grant;
    dmgnt_in = 1'b1;
    tick();
    dmgnt_in = 1'b0;
  endtask

  task automatic give_data(input logic [31:0] w);
    dmdata_in = w;
    dmdata_valid_in = 1'b1;
    tick();
    dmdata_valid_in = 1'b0;
    dmdata_in = 32'h5A5A_5A5A;
  endtask

  task automatic consume;
    lu_ready_in = 1'b1;
    tick();
    lu_ready_in = 1'b0;
  endtask

  task automatic test_reset;
    rst_n_in = 1'b0;
    tick();
    tick();
    n_cmp++; if (ld_ready_out !== 1'b1) begin n_err++; $display("FAIL reset_ready: got %b expected 1", ld_ready_out); end
    n_cmp++; if (dmrd_req_out !== 1'b0) begin n_err++; $display("FAIL reset_dmrd: got %b expected 0", dmrd_req_out); end
    n_cmp++; if (dmaddr_out !== 32'h0) begin n_err++; $display("FAIL reset_dmaddr: got %h expected 0", dmaddr_out); end
    n_cmp++; if (lu_output_out !== 32'h0) begin n_err++; $display("FAIL reset_output: got %h expected 0", lu_output_out); end
    n_cmp++; if (lu_valid_out !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b expected 0", lu_valid_out); end
`ifdef MISALIGN_TRAP_EN
    n_cmp++; if (misaligned_out !== 1'b0) begin n_err++; $display("FAIL reset_misaligned: got %b expected 0", misaligned_out); end
`endif
    rst_n_in = 1'b1;
    tick();
  endtask

  task automatic test_extract;
    logic [2:0]  f3   [7];
    logic [31:0] addr [7];
    logic [31:0] word [7];
    logic [31:0] eaddr[7];
    logic [31:0] edata[7];
    f3[0] = F3_LB;  addr[0] = 32'h1003; word[0] = 32'h80FF_7F01; eaddr[0] = 32'h1000; edata[0] = 32'hFFFF_FF80;
    f3[1] = F3_LBU; addr[1] = 32'h1003; word[1] = 32'h80FF_7F01; eaddr[1] = 32'h1000; edata[1] = 32'h0000_0080;
    f3[2] = F3_LHU; addr[2] = 32'h1002; word[2] = 32'h80FF_7F01; eaddr[2] = 32'h1000; edata[2] = 32'h0000_80FF;
    f3[3] = F3_LH;  addr[3] = 32'h1000; word[3] = 32'h80FF_7F01; eaddr[3] = 32'h1000; edata[3] = 32'h0000_7F01;
    f3[4] = F3_LB;  addr[4] = 32'h1005; word[4] = 32'h0000_1234; eaddr[4] = 32'h1004; edata[4] = 32'h0000_0012;
    f3[5] = F3_LH;  addr[5] = 32'h100A; word[5] = 32'hFFFF_0000; eaddr[5] = 32'h1008; edata[5] = 32'hFFFF_FFFF;
    f3[6] = F3_LW;  addr[6] = 32'hABCD_EF0C; word[6] = 32'h1234_5678; eaddr[6] = 32'hABCD_EF0C; edata[6] = 32'h1234_5678;
    for (int i = 0; i < 7; i++) begin
      issue(f3[i], addr[i]);
      n_cmp++; if (dmrd_req_out !== 1'b1) begin n_err++; $display("FAIL extract%0d_dmrd: got %b expected 1", i, dmrd_req_out); end
      n_cmp++; if (dmaddr_out !== eaddr[i]) begin n_err++; $display("FAIL extract%0d_dmaddr: got %h expected %h", i, dmaddr_out, eaddr[i]); end
      grant();
      give_data(word[i]);
      n_cmp++; if (lu_valid_out !== 1'b1) begin n_err++; $display("FAIL extract%0d_valid: got %b expected 1", i, lu_valid_out); end
      n_cmp++; if (lu_output_out !== edata[i]) begin n_err++; $display("FAIL extract%0d_data: got %h expected %h", i, lu_output_out, edata[i]); end
      consume();
      n_cmp++; if (lu_valid_out !== 1'b0 || ld_ready_out !== 1'b1) begin n_err++; $display("FAIL extract%0d_done: got valid=%b ready=%b expected valid=0 ready=1", i, lu_valid_out, ld_ready_out); end
    end
  endtask

  task automatic test_stall;
    issue(F3_LW, 32'h3008);
    for (int i = 0; i < 4; i++) begin
      n_cmp++; if (dmrd_req_out !== 1'b1) begin n_err++; $display("FAIL stall_req%0d: got %b expected 1", i, dmrd_req_out); end
      n_cmp++; if (dmaddr_out !== 32'h3008) begin n_err++; $display("FAIL stall_addr%0d: got %h expected 00003008", i, dmaddr_out); end
      n_cmp++; if (ld_ready_out !== 1'b0) begin n_err++; $display("FAIL stall_ready%0d: got %b expected 0", i, ld_ready_out); end
      tick();
    end
    n_cmp++; if (dmrd_req_out !== 1'b1 || dmaddr_out !== 32'h3008) begin n_err++; $display("FAIL stall_req_at_grant: got req=%b addr=%h expected req=1 addr=00003008", dmrd_req_out, dmaddr_out); end
    grant();
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (dmrd_req_out !== 1'b0 || lu_valid_out !== 1'b0 || ld_ready_out !== 1'b0) begin n_err++; $display("FAIL stall_wait%0d: got req=%b valid=%b ready=%b expected 0 0 0", i, dmrd_req_out, lu_valid_out, ld_ready_out); end
      tick();
    end
    give_data(32'hDEAD_BEEF);
    n_cmp++; if (lu_valid_out !== 1'b1) begin n_err++; $display("FAIL stall_valid: got %b expected 1", lu_valid_out); end
    n_cmp++; if (lu_output_out !== 32'hDEAD_BEEF) begin n_err++; $display("FAIL stall_data: got %h expected deadbeef", lu_output_out); end
    n_cmp++; if (ld_ready_out !== 1'b0) begin n_err++; $display("FAIL stall_ready_resp: got %b expected 0", ld_ready_out); end
    consume();
  endtask

  task automatic test_back_to_back;
    issue(F3_LBU, 32'h4000);
    grant();
    give_data(32'h0000_00AB);
    // Next load requested while the result is still held.
    ld_req_in = 1'b1;
    funct3_in = F3_LHU;
    iadder_in = 32'h5006;
    for (int i = 0; i < 5; i++) begin
      if (i == 2) begin
        dmdata_in = 32'h1111_2222;
        dmdata_valid_in = 1'b1;
      end else begin
        dmdata_valid_in = 1'b0;
      end
      n_cmp++; if (lu_valid_out !== 1'b1 || lu_output_out !== 32'h0000_00AB) begin n_err++; $display("FAIL hold%0d: got valid=%b data=%h expected valid=1 data=000000ab", i, lu_valid_out, lu_output_out); end
      n_cmp++; if (ld_ready_out !== 1'b0 || dmrd_req_out !== 1'b0) begin n_err++; $display("FAIL hold%0d_ctl: got ready=%b req=%b expected 0 0", i, ld_ready_out, dmrd_req_out); end
      tick();
    end
    dmdata_valid_in = 1'b0;
    n_cmp++; if (lu_output_out !== 32'h0000_00AB) begin n_err++; $display("FAIL hold_after_stray: got %h expected 000000ab", lu_output_out); end
    consume();
    n_cmp++; if (lu_valid_out !== 1'b0 || ld_ready_out !== 1'b1 || dmrd_req_out !== 1'b0) begin n_err++; $display("FAIL b2b_idle: got valid=%b ready=%b req=%b expected 0 1 0", lu_valid_out, ld_ready_out, dmrd_req_out); end
    tick();
    ld_req_in = 1'b0;
    iadder_in = 32'hFFFF_FFFF;
    n_cmp++; if (dmrd_req_out !== 1'b1 || dmaddr_out !== 32'h5004) begin n_err++; $display("FAIL b2b_req: got req=%b addr=%h expected req=1 addr=00005004", dmrd_req_out, dmaddr_out); end
    grant();
    give_data(32'hCAFE_1234);
    n_cmp++; if (lu_valid_out !== 1'b1 || lu_output_out !== 32'h0000_CAFE) begin n_err++; $display("FAIL b2b_data: got valid=%b data=%h expected valid=1 data=0000cafe", lu_valid_out, lu_output_out); end
    consume();
  endtask

  task automatic test_reset_in_wait;
    issue(F3_LW, 32'h6000);
    grant();
    rst_n_in = 1'b0;
    #1;
    n_cmp++; if (ld_ready_out !== 1'b1 || dmrd_req_out !== 1'b0 || lu_valid_out !== 1'b0) begin n_err++; $display("FAIL rstwait_ctl: got ready=%b req=%b valid=%b expected 1 0 0", ld_ready_out, dmrd_req_out, lu_valid_out); end
    n_cmp++; if (dmaddr_out !== 32'h0 || lu_output_out !== 32'h0) begin n_err++; $display("FAIL rstwait_regs: got addr=%h data=%h expected 0 0", dmaddr_out, lu_output_out); end
    tick();
    rst_n_in = 1'b1;
    tick();
    give_data(32'h1234_5678);
    for (int i = 0; i < 2; i++) begin
      n_cmp++; if (lu_valid_out !== 1'b0 || ld_ready_out !== 1'b1 || lu_output_out !== 32'h0) begin n_err++; $display("FAIL rstwait_late%0d: got valid=%b ready=%b data=%h expected 0 1 0", i, lu_valid_out, ld_ready_out, lu_output_out); end
      tick();
    end
    issue(F3_LH, 32'h7002);
    n_cmp++; if (dmaddr_out !== 32'h7000) begin n_err++; $display("FAIL rstwait_next_addr: got %h expected 00007000", dmaddr_out); end
    grant();
    give_data(32'h8001_4444);
    n_cmp++; if (lu_valid_out !== 1'b1 || lu_output_out !== 32'hFFFF_8001) begin n_err++; $display("FAIL rstwait_next_data: got valid=%b data=%h expected valid=1 data=ffff8001", lu_valid_out, lu_output_out); end
    consume();
  endtask

  task automatic test_misalign;
`ifdef MISALIGN_TRAP_EN
    issue(F3_LW, 32'h2001);
    n_cmp++; if (dmrd_req_out !== 1'b0) begin n_err++; $display("FAIL mis_lw_noreq: got %b expected 0", dmrd_req_out); end
    n_cmp++; if (lu_valid_out !== 1'b1 || misaligned_out !== 1'b1 || lu_output_out !== 32'h0) begin n_err++; $display("FAIL mis_lw: got valid=%b mis=%b data=%h expected 1 1 0", lu_valid_out, misaligned_out, lu_output_out); end
    tick();
    n_cmp++; if (lu_valid_out !== 1'b1 || misaligned_out !== 1'b1) begin n_err++; $display("FAIL mis_lw_hold: got valid=%b mis=%b expected 1 1", lu_valid_out, misaligned_out); end
    consume();
    n_cmp++; if (lu_valid_out !== 1'b0 || misaligned_out !== 1'b0) begin n_err++; $display("FAIL mis_lw_clear: got valid=%b mis=%b expected 0 0", lu_valid_out, misaligned_out); end
    issue(F3_LH, 32'h2003);
    n_cmp++; if (dmrd_req_out !== 1'b0 || misaligned_out !== 1'b1 || lu_valid_out !== 1'b1) begin n_err++; $display("FAIL mis_lh: got req=%b mis=%b valid=%b expected 0 1 1", dmrd_req_out, misaligned_out, lu_valid_out); end
    consume();
    issue(F3_LHU, 32'h2002);
    n_cmp++; if (dmrd_req_out !== 1'b1 || dmaddr_out !== 32'h2000) begin n_err++; $display("FAIL mis_lhu_ok_req: got req=%b addr=%h expected req=1 addr=00002000", dmrd_req_out, dmaddr_out); end
    grant();
    give_data(32'hABCD_0000);
    n_cmp++; if (misaligned_out !== 1'b0 || lu_output_out !== 32'h0000_ABCD) begin n_err++; $display("FAIL mis_lhu_ok: got mis=%b data=%h expected mis=0 data=0000abcd", misaligned_out, lu_output_out); end
    consume();
`else
    issue(F3_LW, 32'h2001);
    n_cmp++; if (dmrd_req_out !== 1'b1 || dmaddr_out !== 32'h2000) begin n_err++; $display("FAIL nomis_lw_req: got req=%b addr=%h expected req=1 addr=00002000", dmrd_req_out, dmaddr_out); end
    grant();
    give_data(32'h1122_3344);
    n_cmp++; if (lu_valid_out !== 1'b1 || lu_output_out !== 32'h1122_3344) begin n_err++; $display("FAIL nomis_lw: got valid=%b data=%h expected valid=1 data=11223344", lu_valid_out, lu_output_out); end
    consume();
    issue(F3_LH, 32'h2003);
    n_cmp++; if (dmrd_req_out !== 1'b1 || dmaddr_out !== 32'h2000) begin n_err++; $display("FAIL nomis_lh_req: got req=%b addr=%h expected req=1 addr=00002000", dmrd_req_out, dmaddr_out); end
    grant();
    give_data(32'hABCD_0000);
    n_cmp++; if (lu_output_out !== 32'hFFFF_ABCD) begin n_err++; $display("FAIL nomis_lh: got %h expected ffffabcd", lu_output_out); end
    consume();
`endif
  endtask

  initial begin
    test_reset();
    test_extract();
    test_stall();
    test_back_to_back();
    test_reset_in_wait();
    test_misalign();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
